// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared enums for the tug-of-war playfield
package tug_pkg;

   typedef enum logic [1:0] {
      WIN_NONE  = 2'd0,
      WIN_LEFT  = 2'd1,
      WIN_RIGHT = 2'd2
   } winner_t;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      WIN   = 2'd1,
      MATCH = 2'd2
   } state_t;

endpackage

// File: rtl/tug_score_counter.sv
// rtl/tug_score_counter.sv - saturating round-score counter with match-reached flag
module tug_score_counter
   import tug_pkg::*;
#(
   parameter int SCORE_W    = 3,
   parameter int MATCH_WINS = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               clear,
   output logic [SCORE_W-1:0] count,
   output logic               reach
);

   localparam logic [SCORE_W-1:0] CNT_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] CNT_WIN = SCORE_W'(MATCH_WINS);

   logic [SCORE_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign reach = (count_q == CNT_WIN);

endmodule

// File: rtl/tug_playfield.sv
// rtl/tug_playfield.sv - tug-of-war rope tracker, round/match scoring; TUG_AUTO_RESTART_EN selects timed WIN exit
module tug_playfield
   import tug_pkg::*;
#(
   parameter int NUM_LIGHTS  = 9,
   parameter int SCORE_W     = 3,
   parameter int MATCH_WINS  = 5
`ifdef TUG_AUTO_RESTART_EN
   ,
   parameter int RESTART_CYC = 8
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  L,
   input  logic                  R,
   input  logic                  new_round,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [1:0]            winner,
   output logic [SCORE_W-1:0]    left_score,
   output logic [SCORE_W-1:0]    right_score,
   output logic                  match_over
);

   localparam int PW = (NUM_LIGHTS > 2) ? $clog2(NUM_LIGHTS) : 1;
   localparam logic [PW-1:0] POS_MAX = PW'(NUM_LIGHTS - 1);
   localparam logic [PW-1:0] POS_C   = PW'((NUM_LIGHTS - 1) / 2);
   localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(MATCH_WINS - 1);

   state_t                  state_q, state_d;
   logic [PW-1:0]           pos_q, pos_d;
   logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
   winner_t                 winner_q, winner_d;
   logic                    inc_l, inc_r;
   logic                    reach_l, reach_r;
   logic                    round_won, match_won;
   logic [SCORE_W-1:0]      score_l, score_r;

`ifdef TUG_AUTO_RESTART_EN
   localparam int TW = $clog2(RESTART_CYC + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          unused_new_round;
   assign unused_new_round = new_round;
`endif

   function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [PW-1:0] p);
      return {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << p;
   endfunction

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      lights_d  = lights_q;
      winner_d  = winner_q;
      inc_l     = 1'b0;
      inc_r     = 1'b0;
      round_won = 1'b0;
      match_won = 1'b0;
`ifdef TUG_AUTO_RESTART_EN
      timer_d   = timer_q;
`endif
      case (state_q)
         PLAY: begin
            if (L && !R) begin
               if (pos_q == POS_MAX) begin
                  inc_l     = 1'b1;
                  winner_d  = WIN_LEFT;
                  round_won = 1'b1;
                  match_won = (score_l == SCORE_LAST);
               end else begin
                  pos_d    = pos_q + 1'b1;
                  lights_d = onehot(pos_q + 1'b1);
               end
            end else if (R && !L) begin
               if (pos_q == '0) begin
                  inc_r     = 1'b1;
                  winner_d  = WIN_RIGHT;
                  round_won = 1'b1;
                  match_won = (score_r == SCORE_LAST);
               end else begin
                  pos_d    = pos_q - 1'b1;
                  lights_d = onehot(pos_q - 1'b1);
               end
            end
            // A round win that completes the match skips WIN entirely.
            if (round_won) begin
               if (match_won) begin
                  state_d  = MATCH;
                  lights_d = '1;
               end else begin
                  state_d  = WIN;
                  lights_d = '0;
`ifdef TUG_AUTO_RESTART_EN
                  timer_d  = TW'(RESTART_CYC);
`endif
               end
            end
         end
         WIN: begin
`ifdef TUG_AUTO_RESTART_EN
            if (timer_q == TW'(1)) begin
`else
            if (new_round) begin
`endif
               state_d  = PLAY;
               pos_d    = POS_C;
               lights_d = onehot(POS_C);
               winner_d = WIN_NONE;
            end
`ifdef TUG_AUTO_RESTART_EN
            else begin
               timer_d = timer_q - 1'b1;
            end
`endif
         end
         MATCH: begin
            state_d = MATCH;
         end
         default: begin
            state_d  = PLAY;
            pos_d    = POS_C;
            lights_d = onehot(POS_C);
            winner_d = WIN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= PLAY;
         pos_q    <= POS_C;
         lights_q <= onehot(POS_C);
         winner_q <= WIN_NONE;
`ifdef TUG_AUTO_RESTART_EN
         timer_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         lights_q <= lights_d;
         winner_q <= winner_d;
`ifdef TUG_AUTO_RESTART_EN
         timer_q  <= timer_d;
`endif
      end
   end

   tug_score_counter #(
      .SCORE_W    (SCORE_W),
      .MATCH_WINS (MATCH_WINS)
   ) u_score_left (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_l),
      .clear (1'b0),
      .count (score_l),
      .reach (reach_l)
   );

   tug_score_counter #(
      .SCORE_W    (SCORE_W),
      .MATCH_WINS (MATCH_WINS)
   ) u_score_right (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_r),
      .clear (1'b0),
      .count (score_r),
      .reach (reach_r)
   );

   assign lights      = lights_q;
   assign winner      = winner_q;
   assign left_score  = score_l;
   assign right_score = score_r;
   assign match_over  = reach_l | reach_r;

endmodule
